// File: rtl/eth_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : eth_frame_tx
// Brief    : Ethernet transmit framer: preamble/SFD, pad, CRC-32 FCS, IFG.
// Revision : 1.0
// ============================================================================
module eth_frame_tx #(
    parameter int MIN_PAYLOAD = 60,
    parameter int IFG_BYTES   = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [15:0] C_MIN      = 16'(MIN_PAYLOAD);
    localparam logic [15:0] C_IFG_LAST = 16'(IFG_BYTES - 1);
    localparam logic [31:0] C_CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_PAYLOAD  = 3'd2,
        S_PAD      = 3'd3,
        S_FCS      = 3'd4,
        S_DRAIN    = 3'd5,
        S_IFG      = 3'd6
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_crc, w_crc_nxt;
    logic [15:0] r_count, w_count_nxt, w_count_inc;
    logic [15:0] r_step, w_step_nxt;
    logic [31:0] w_fcs;
    logic [7:0]  w_fcs_byte;
    logic [7:0]  w_txd_nxt;
    logic        w_en_nxt, w_er_nxt, w_done_nxt, w_under_nxt;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign s_tready    = (r_state == S_PAYLOAD) || (r_state == S_DRAIN);
    assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
    assign w_fcs       = ~r_crc;

    always_comb begin
        case (r_step[1:0])
            2'd0:    w_fcs_byte = w_fcs[7:0];
            2'd1:    w_fcs_byte = w_fcs[15:8];
            2'd2:    w_fcs_byte = w_fcs[23:16];
            default: w_fcs_byte = w_fcs[31:24];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_crc_nxt   = r_crc;
        w_count_nxt = r_count;
        w_step_nxt  = r_step;
        w_txd_nxt   = 8'h00;
        w_en_nxt    = 1'b0;
        w_er_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_under_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s_tvalid) begin
                    w_state_nxt = S_PREAMBLE;
                    w_crc_nxt   = C_CRC_INIT;
                    w_count_nxt = 16'd0;
                    w_step_nxt  = 16'd0;
                end
            end
            S_PREAMBLE: begin
                w_en_nxt  = 1'b1;
                w_txd_nxt = (r_step == 16'd7) ? 8'hD5 : 8'h55;
                if (r_step == 16'd7) begin
                    w_state_nxt = S_PAYLOAD;
                    w_step_nxt  = 16'd0;
                end else begin
                    w_step_nxt = r_step + 16'd1;
                end
            end
            S_PAYLOAD: begin
                w_en_nxt = 1'b1;
                if (s_tvalid) begin
                    w_txd_nxt   = s_tdata;
                    w_crc_nxt   = crc_byte(r_crc, s_tdata);
                    w_count_nxt = w_count_inc;
                    if (s_tlast) begin
                        w_state_nxt = (w_count_inc < C_MIN) ? S_PAD : S_FCS;
                        w_step_nxt  = 16'd0;
                    end
                end else begin
                    w_er_nxt    = 1'b1;
                    w_under_nxt = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_PAD: begin
                w_en_nxt    = 1'b1;
                w_crc_nxt   = crc_byte(r_crc, 8'h00);
                w_count_nxt = w_count_inc;
                if (w_count_inc >= C_MIN) begin
                    w_state_nxt = S_FCS;
                    w_step_nxt  = 16'd0;
                end
            end
            S_FCS: begin
                w_en_nxt  = 1'b1;
                w_txd_nxt = w_fcs_byte;
                if (r_step == 16'd3) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IFG;
                    w_step_nxt  = 16'd0;
                end else begin
                    w_step_nxt = r_step + 16'd1;
                end
            end
            S_DRAIN: begin
                if (s_tvalid && s_tlast) begin
                    w_state_nxt = S_IFG;
                    w_step_nxt  = 16'd0;
                end
            end
            S_IFG: begin
                // The last gap cycle doubles as the idle cycle, so a pending
                // frame starts without stretching the gap past IFG_BYTES.
                if (r_step == C_IFG_LAST) begin
                    w_step_nxt = 16'd0;
                    if (s_tvalid) begin
                        w_state_nxt = S_PREAMBLE;
                        w_crc_nxt   = C_CRC_INIT;
                        w_count_nxt = 16'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_step_nxt = r_step + 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_crc      <= C_CRC_INIT;
            r_count    <= 16'd0;
            r_step     <= 16'd0;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_crc      <= w_crc_nxt;
            r_count    <= w_count_nxt;
            r_step     <= w_step_nxt;
            gmii_txd   <= w_txd_nxt;
            gmii_tx_en <= w_en_nxt;
            gmii_tx_er <= w_er_nxt;
            frame_done <= w_done_nxt;
            underrun   <= w_under_nxt;
        end
    end

endmodule
`default_nettype wire
